// File: rtl/de_arb_pkg.sv
// Shared types and default sizing for the decrypted-data RAM arbiter.
// Pure definitions, no logic, no latency.
// No flow control of its own; consumed by de_mem_arbiter and de_rr_picker.
package de_arb_pkg;

  // Arbiter sequencing: accept in IDLE, drive RAM in ISSUE, collect read data in RDWAIT
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } arb_state_t;

  localparam int DE_ARB_NUM_REQ  = 3;
  localparam int DE_ARB_ADDR_W   = 5;
  localparam int DE_ARB_DATA_W   = 8;
  localparam int DE_ARB_LOCK_MAX = 32;

  // Supported requester range
  localparam int DE_ARB_NUM_REQ_MIN = 2;
  localparam int DE_ARB_NUM_REQ_MAX = 8;

  // Width of a requester index (at least one bit)
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/de_rr_picker.sv
// Rotate-priority encoder: first set request at or after ptr, wrapping, as one-hot and index.
// Purely combinational, zero latency.
// No backpressure; win_any low when no request is set.
module de_rr_picker
  import de_arb_pkg::*;
#(
  parameter int NUM_REQ = DE_ARB_NUM_REQ,
  parameter int IDX_W   = idx_width(DE_ARB_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IDX_W-1:0]   win_idx,
  output logic               win_any
);

  // Scan requesters starting at ptr; the first hit wins
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int j;
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!win_any && req[j]) begin
        win_any    = 1'b1;
        win_idx    = IDX_W'(j);
        win_oh[j]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/de_mem_arbiter.sv
// Round-robin arbiter owning the single-port 32x8 decrypted-data RAM; one access per grant.
// Latency: gnt 1 cycle after req sampled in IDLE; rd_valid 2 cycles after gnt; write every 2, read every 3 cycles.
// Backpressure: requesters hold req until their gnt pulse; no resampling while ISSUE/RDWAIT. Optional burst lock: DE_ARB_LOCK_EN.
module de_mem_arbiter
  import de_arb_pkg::*;
#(
  parameter int NUM_REQ  = DE_ARB_NUM_REQ,
  parameter int ADDR_W   = DE_ARB_ADDR_W,
  parameter int DATA_W   = DE_ARB_DATA_W,
  parameter int LOCK_MAX = DE_ARB_LOCK_MAX
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
`ifdef DE_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [DATA_W-1:0]         mem_data,
  output logic                      mem_wren,
  input  logic [DATA_W-1:0]         mem_q
);

  localparam int IDX_W = idx_width(NUM_REQ);

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(NUM_REQ - 1)) return '0;
    return i + 1'b1;
  endfunction

  function automatic logic [NUM_REQ-1:0] idx_to_oh(input logic [IDX_W-1:0] i);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

  arb_state_t         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   cur_idx;
  logic               cur_we;

  logic [NUM_REQ-1:0] pick_req;
  logic [IDX_W-1:0]   pick_ptr;
  logic [NUM_REQ-1:0] win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;

`ifdef DE_ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic               lock_vld;
  logic [IDX_W-1:0]   lock_idx;
  logic [CNT_W-1:0]   lock_cnt;
  logic               cur_locked;
  logic               lock_hold;
  logic               lock_release;

  // Lock survives while its owner keeps req and req_lock and the burst budget is not spent
  assign lock_hold    = lock_vld && req[lock_idx] && req_lock[lock_idx] &&
                        (lock_cnt < CNT_W'(LOCK_MAX));
  assign lock_release = lock_vld && !lock_hold;

  // Restrict candidates to the lock owner, or restart round-robin just past it on release
  always_comb begin
    pick_req = req;
    pick_ptr = rr_ptr;
    if (lock_hold) begin
      pick_req = req & idx_to_oh(lock_idx);
      pick_ptr = lock_idx;
    end else if (lock_release) begin
      pick_ptr = next_idx(lock_idx);
    end
  end
`else
  assign pick_req = req;
  assign pick_ptr = rr_ptr;
`endif

  de_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req     (pick_req),
    .ptr     (pick_ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_any (win_any)
  );

  // Access sequencer: all RAM-side signals and pulses are registered here
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= '0;
      rd_valid    <= '0;
      mem_wren    <= 1'b0;
      rd_data     <= '0;
      mem_address <= '0;
      mem_data    <= '0;
      rr_ptr      <= '0;
      cur_idx     <= '0;
      cur_we      <= 1'b0;
`ifdef DE_ARB_LOCK_EN
      lock_vld    <= 1'b0;
      lock_idx    <= '0;
      lock_cnt    <= '0;
      cur_locked  <= 1'b0;
`endif
    end else begin
      gnt      <= '0;
      rd_valid <= '0;
      mem_wren <= 1'b0;
      case (state)
        IDLE: begin
`ifdef DE_ARB_LOCK_EN
          if (lock_release) begin
            lock_vld <= 1'b0;
            lock_cnt <= '0;
            rr_ptr   <= next_idx(lock_idx);
          end
`endif
          if (win_any) begin
            mem_address <= req_addr[win_idx*ADDR_W +: ADDR_W];
            mem_data    <= req_wdata[win_idx*DATA_W +: DATA_W];
            mem_wren    <= req_we[win_idx];
            gnt         <= win_oh;
            cur_idx     <= win_idx;
            cur_we      <= req_we[win_idx];
            state       <= ISSUE;
`ifdef DE_ARB_LOCK_EN
            cur_locked  <= req_lock[win_idx];
            if (req_lock[win_idx]) begin
              lock_vld <= 1'b1;
              lock_idx <= win_idx;
              lock_cnt <= lock_hold ? lock_cnt + 1'b1 : CNT_W'(1);
            end
`endif
          end
        end
        ISSUE: begin
          // RAM samples address/data/wren at the end of this cycle
`ifdef DE_ARB_LOCK_EN
          if (!cur_locked) rr_ptr <= next_idx(cur_idx);
`else
          rr_ptr <= next_idx(cur_idx);
`endif
          state <= cur_we ? IDLE : RDWAIT;
        end
        RDWAIT: begin
          rd_data  <= mem_q;
          rd_valid <= idx_to_oh(cur_idx);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_de_mem_arbiter.sv
// Bench for de_mem_arbiter with a behavioural 32x8 registered-output RAM.
// Grants and read returns are checked against scoreboard queues at negedge.
// Lock burst scenario is exercised only when DE_ARB_LOCK_EN is defined.
module tb_de_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req = '0;
  logic [2:0]  req_we = '0;
  logic [14:0] req_addr = '0;
  logic [23:0] req_wdata = '0;
`ifdef DE_ARB_LOCK_EN
  logic [2:0]  req_lock = '0;
`endif
  logic [2:0]  gnt;
  logic [2:0]  rd_valid;
  logic [7:0]  rd_data;
  logic [4:0]  mem_address;
  logic [7:0]  mem_data;
  logic        mem_wren;
  logic [7:0]  mem_q = '0;

  logic [7:0]  ram [32];

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0] gnt;
    logic       we;
    logic [4:0] addr;
    logic [7:0] data;
  } gnt_exp_t;

  typedef struct {
    logic [2:0] rdv;
    logic [7:0] data;
  } rd_exp_t;

  typedef struct {
    int         idx;
    bit         we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  gnt_exp_t gnt_q[$];
  rd_exp_t  rd_q[$];
  gnt_exp_t mon_g;
  rd_exp_t  mon_r;

  always #5 clk = ~clk;

  de_mem_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
`ifdef DE_ARB_LOCK_EN
    .req_lock    (req_lock),
`endif
    .gnt         (gnt),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q)
  );

  // Single-port RAM, write on wren, q registered one cycle after address
  always @(posedge clk) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    mem_q <= ram[mem_address];
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (gnt != 3'b000) begin
        n_cmp++;
        if (gnt_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_gnt: got gnt=%b, no grant expected", gnt);
        end else begin
          mon_g = gnt_q.pop_front();
          if (gnt !== mon_g.gnt || mem_wren !== mon_g.we || mem_address !== mon_g.addr ||
              (mon_g.we && mem_data !== mon_g.data)) begin
            n_fail++;
            $display("FAIL grant: got gnt=%b wren=%b addr=%0d data=%h, want gnt=%b wren=%b addr=%0d data=%h",
                     gnt, mem_wren, mem_address, mem_data, mon_g.gnt, mon_g.we, mon_g.addr, mon_g.data);
          end
        end
      end
      if (rd_valid != 3'b000) begin
        n_cmp++;
        if (rd_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rd_valid: got rd_valid=%b data=%h, none expected", rd_valid, rd_data);
        end else begin
          mon_r = rd_q.pop_front();
          if (rd_valid !== mon_r.rdv || rd_data !== mon_r.data) begin
            n_fail++;
            $display("FAIL read_return: got rd_valid=%b data=%h, want rd_valid=%b data=%h",
                     rd_valid, rd_data, mon_r.rdv, mon_r.data);
          end
        end
      end
      if (mem_wren) begin
        n_cmp++;
        if (gnt == 3'b000) begin
          n_fail++;
          $display("FAIL wren_without_gnt: got wren=1 gnt=%b, want a grant alongside", gnt);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input int idx, input bit we, input logic [4:0] a, input logic [7:0] d);
    req[idx]             = 1'b1;
    req_we[idx]          = we;
    req_addr[idx*5 +: 5] = a;
    req_wdata[idx*8 +: 8] = d;
  endtask

  // One isolated access; caller sits at a negedge with the arbiter idle
  task automatic do_access(input int idx, input bit we, input logic [4:0] a,
                           input logic [7:0] d, input logic [7:0] exp_rd);
    logic [2:0] oh;
    int n;
    oh = 3'b001 << idx;
    gnt_q.push_back('{gnt: oh, we: we, addr: a, data: d});
    if (!we) rd_q.push_back('{rdv: oh, data: exp_rd});
    drive_req(idx, we, a, d);
    n = 0;
    do begin @(negedge clk); n++; end while (gnt[idx] !== 1'b1 && n < 20);
    check("gnt_latency", n, 1);
    req[idx] = 1'b0;
    if (!we) begin
      n = 0;
      do begin @(negedge clk); n++; end while (rd_valid[idx] !== 1'b1 && n < 20);
      check("rd_valid_latency", n, 2);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t tbl [8];

  initial begin
    int gcount;
    int seen;
    int rdv_seen;
    logic [7:0] v;

    tbl[0] = '{idx: 0, we: 1'b1, addr: 5'd5,  wdata: 8'hA3, exp_rd: 8'h00};
    tbl[1] = '{idx: 1, we: 1'b0, addr: 5'd5,  wdata: 8'h00, exp_rd: 8'hA3};
    tbl[2] = '{idx: 2, we: 1'b1, addr: 5'd31, wdata: 8'h3C, exp_rd: 8'h00};
    tbl[3] = '{idx: 0, we: 1'b0, addr: 5'd31, wdata: 8'h00, exp_rd: 8'h3C};
    tbl[4] = '{idx: 1, we: 1'b1, addr: 5'd0,  wdata: 8'hFF, exp_rd: 8'h00};
    tbl[5] = '{idx: 2, we: 1'b0, addr: 5'd0,  wdata: 8'h00, exp_rd: 8'hFF};
    tbl[6] = '{idx: 0, we: 1'b1, addr: 5'd5,  wdata: 8'h00, exp_rd: 8'h00};
    tbl[7] = '{idx: 1, we: 1'b0, addr: 5'd5,  wdata: 8'h00, exp_rd: 8'h00};

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_gnt", gnt, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_mem_wren", mem_wren, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_mem_address", mem_address, 0);
    check("reset_mem_data", mem_data, 0);

    // Table-driven single accesses
    for (int i = 0; i < 8; i++)
      do_access(tbl[i].idx, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd);

    // Contention: all three held after reset -> 0,1,2,0,1,2,...
    do_reset();
    for (int k = 0; k < 9; k++)
      gnt_q.push_back('{gnt: 3'b001 << (k % 3), we: 1'b1, addr: 5'(10 + (k % 3)), data: 8'(8'h10 + (k % 3))});
    for (int r = 0; r < 3; r++) drive_req(r, 1'b1, 5'(10 + r), 8'(8'h10 + r));
    gcount = 0;
    for (int c = 0; c < 60 && gcount < 9; c++) begin
      @(negedge clk);
      if (gnt != 3'b000) gcount++;
    end
    req = '0;
    check("contention_grants", gcount, 9);
    @(negedge clk);

    // Fill via requester 2, read back via requester 0
    for (int a = 0; a < 32; a++) do_access(2, 1'b1, 5'(a), 8'(a) ^ 8'h5A, 8'h00);
    for (int a = 0; a < 32; a++) begin
      v = 8'(a) ^ 8'h5A;
      do_access(0, 1'b0, 5'(a), 8'h00, v);
    end

    // Reset while the read sits in RDWAIT
    gnt_q.push_back('{gnt: 3'b010, we: 1'b0, addr: 5'd3, data: 8'h00});
    drive_req(1, 1'b0, 5'd3, 8'h00);
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (gnt[1] === 1'b1) seen = 1;
    end
    check("rdwait_gnt_seen", seen, 1);
    req[1] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("after_reset_rd_valid", rd_valid, 0);
    check("after_reset_mem_wren", mem_wren, 0);
    rdv_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rd_valid != 3'b000) rdv_seen++;
    end
    check("discarded_read", rdv_seen, 0);
    // Pointer back at 0: requester 1 must beat requester 2
    gnt_q.push_back('{gnt: 3'b010, we: 1'b1, addr: 5'd20, data: 8'h77});
    drive_req(1, 1'b1, 5'd20, 8'h77);
    drive_req(2, 1'b1, 5'd21, 8'h88);
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (gnt != 3'b000) seen = 1;
    end
    req = '0;
    check("post_reset_winner", gnt, 3'b010);
    @(negedge clk);

`ifdef DE_ARB_LOCK_EN
    // Locked burst of 40 reads from requester 1 with requester 0 waiting
    begin
      int c1;
      int done0;
      for (int k = 0; k < 40; k++) begin
        if (k == 32) gnt_q.push_back('{gnt: 3'b001, we: 1'b1, addr: 5'd9, data: 8'h99});
        gnt_q.push_back('{gnt: 3'b010, we: 1'b0, addr: 5'd7, data: 8'h00});
        rd_q.push_back('{rdv: 3'b010, data: 8'h5D});
      end
      drive_req(1, 1'b0, 5'd7, 8'h00);
      req_lock[1] = 1'b1;
      c1 = 0;
      done0 = 0;
      for (int c = 0; c < 400 && (c1 < 40 || done0 == 0); c++) begin
        @(negedge clk);
        if (gnt[1] === 1'b1) begin
          c1++;
          if (c1 == 1) drive_req(0, 1'b1, 5'd9, 8'h99);
          if (c1 == 40) begin
            req[1] = 1'b0;
            req_lock[1] = 1'b0;
          end
        end
        if (gnt[0] === 1'b1) begin
          req[0] = 1'b0;
          done0 = 1;
        end
      end
      check("lock_grants_req1", c1, 40);
      check("lock_grant_req0", done0, 1);
    end
`endif

    // Drain outstanding expectations
    for (int k = 0; k < 50 && (gnt_q.size() != 0 || rd_q.size() != 0); k++) @(negedge clk);
    check("gnt_queue_drained", gnt_q.size(), 0);
    check("rd_queue_drained", rd_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion before it");
    $fatal(1, "watchdog");
  end

endmodule
